// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths, occupancy states and decode helper for the 3-to-8 decoder
package decoder_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // One-hot word with bit `code` set, or all zeros when the decode is disabled.
    function automatic logic [OUT_W-1:0] onehot3(input logic [IN_W-1:0] code, input logic en);
        logic [OUT_W-1:0] w;
        w = '0;
        if (en) begin
            w[code] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_dec_3_8.sv
// rtl/onehot_dec_3_8.sv - combinational 3-to-8 decoder with enable and optional output inversion
module onehot_dec_3_8
    import decoder_pkg::*;
(
    input  logic [IN_W-1:0]  code_i,
    input  logic             en_i,
    input  logic             inv_i,
    output logic [OUT_W-1:0] word_o
);

    // inv_i turns the one-hot word into a one-cold word for active-low selects.
    assign word_o = onehot3(code_i, en_i) ^ {OUT_W{inv_i}};

endmodule

// File: rtl/decoder_3_8_stream.sv
// rtl/decoder_3_8_stream.sv - flow-controlled 3-to-8 decoder with 2-entry skid buffer and transfer counter
module decoder_3_8_stream
    import decoder_pkg::*;
#(
    parameter bit OUT_INV = 1'b0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [CNT_W-1:0] dec_count
);

    occ_t             state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] dec_word;
    logic             in_fire;
    logic             out_fire;

    // Words are decoded on entry so the buffer only ever holds final output values.
    onehot_dec_3_8 u_dec (
        .code_i (in_code),
        .en_i   (in_en),
        .inv_i  (OUT_INV),
        .word_o (dec_word)
    );

    // Handshakes depend only on registered state; in_ready is held low during reset.
    assign out_valid  = (state_q != EMPTY);
    assign in_ready   = ~rst & (state_q != FULL);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign out_onehot = head_q;
    assign dec_count  = cnt_q;

    // Occupancy FSM: head feeds the output, skid catches one word while the consumer stalls.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    head_d  = dec_word;
                end
            end
            ONE: begin
                unique case ({in_fire, out_fire})
                    2'b10: begin
                        state_d = FULL;
                        skid_d  = dec_word;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d  = dec_word;
                    default: ;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Transfer counter wraps silently at 2^CNT_W.
    always_comb begin
        cnt_d = out_fire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Reset discards buffered words and parks the output at the disabled-decode value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= {OUT_W{OUT_INV}};
            skid_q  <= {OUT_W{OUT_INV}};
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decoder_3_8_stream.sv
// tb/tb_decoder_3_8_stream.sv - self-checking bench for decoder_3_8_stream (plain and inverted/narrow-counter instances)
module tb_decoder_3_8_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_en;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] onehot_a, onehot_b, cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    decoder_3_8_stream #(.OUT_INV(1'b0), .CNT_W(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_onehot (onehot_a),
        .dec_count  (cnt_a)
    );

    decoder_3_8_stream #(.OUT_INV(1'b1), .CNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_onehot (onehot_b),
        .dec_count  (cnt_b)
    );

    typedef struct packed {
        logic       valid_a;
        logic       ready_a;
        logic       valid_b;
        logic       ready_b;
        logic [7:0] word_a;
        logic [7:0] word_b;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
    } snap_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mq[$];
    logic [7:0]  last_word;
    int unsigned n_xfer;

    function automatic logic [7:0] ref_decode(input logic [2:0] c, input logic e);
        return e ? 8'(2 ** int'(c)) : 8'h00;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.valid_a = out_valid_a;
        s.ready_a = in_ready_a;
        s.valid_b = out_valid_b;
        s.ready_b = in_ready_b;
        s.word_a  = onehot_a;
        s.word_b  = onehot_b;
        s.cnt_a   = cnt_a;
        s.cnt_b   = cnt_b;
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        last_word = 8'h00;
        n_xfer    = 0;
    endtask

    // One clock: drive inputs, sample both DUTs before the edge, predict from the FIFO model, advance.
    task automatic do_cycle(input logic v, input logic [2:0] c, input logic e, input logic r,
                            output snap_t exp_s, output snap_t obs_s, output logic acc);
        logic       drn;
        logic [7:0] head;
        in_valid  = v;
        in_code   = c;
        in_en     = e;
        out_ready = r;
        @(negedge clk);
        head          = (mq.size() > 0) ? mq[0] : last_word;
        exp_s.valid_a = (mq.size() > 0);
        exp_s.ready_a = (mq.size() < 2);
        exp_s.valid_b = (mq.size() > 0);
        exp_s.ready_b = (mq.size() < 2);
        exp_s.word_a  = head;
        exp_s.word_b  = ~head;
        exp_s.cnt_a   = 8'(n_xfer % 256);
        exp_s.cnt_b   = 2'(n_xfer % 4);
        obs_s         = observe();
        acc = v && (mq.size() < 2);
        drn = r && (mq.size() > 0);
        if (drn) begin
            last_word = mq.pop_front();
            n_xfer++;
        end
        if (acc) mq.push_back(ref_decode(c, e));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t o, e;
        rst = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0; out_ready = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        e = '{valid_a: 1'b0, ready_a: 1'b0, valid_b: 1'b0, ready_b: 1'b0,
              word_a: 8'h00, word_b: 8'hFF, cnt_a: 8'h00, cnt_b: 2'd0};
        o = observe();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_state got %h exp %h", o, e); end
        #4 rst = 1'b0;
        #1;
        o = observe();
        checks++;
        if ({o.ready_a, o.ready_b, o.valid_a} !== 3'b110) begin
            errors++; $display("FAIL reset_release ready/valid got %b exp 110", {o.ready_a, o.ready_b, o.valid_a});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        snap_t      o, e;
        logic       acc;
        logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int k = 0; k < 10; k++) begin
            do_cycle(k < 8, 3'(k), 1'b1, 1'b1, e, o, acc);
            checks++;
            if (o !== e) begin errors++; $display("FAIL sweep cyc %0d got %h exp %h", k, o, e); end
            if (k >= 1 && k <= 8) begin
                checks++;
                if ({o.valid_a, o.word_a} !== {1'b1, sweep_exp[k-1]}) begin
                    errors++; $display("FAIL sweep_word %0d got %b/%h exp 1/%h", k - 1, o.valid_a, o.word_a, sweep_exp[k-1]);
                end
            end
        end
        checks++;
        if (o.cnt_a !== 8'd8) begin errors++; $display("FAIL sweep_count got %0d exp 8", o.cnt_a); end
    endtask

    task automatic test_enable_low();
        snap_t o, e;
        logic  acc;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       do_cycle(1'b1, 3'd5, 1'b0, 1'b1, e, o, acc);
                1:       do_cycle(1'b1, 3'd2, 1'b1, 1'b1, e, o, acc);
                default: do_cycle(1'b0, 3'd0, 1'b0, 1'b1, e, o, acc);
            endcase
            checks++;
            if (o !== e) begin errors++; $display("FAIL enable cyc %0d got %h exp %h", k, o, e); end
            if (k == 1) begin
                checks++;
                if ({o.valid_a, o.word_a, o.word_b} !== {1'b1, 8'h00, 8'hFF}) begin
                    errors++; $display("FAIL enable_low_word got %b/%h/%h exp 1/00/ff", o.valid_a, o.word_a, o.word_b);
                end
            end
            if (k == 2) begin
                checks++;
                if (o.word_b !== 8'hFB) begin errors++; $display("FAIL inv_code2 got %h exp fb", o.word_b); end
            end
        end
    endtask

    task automatic test_backpressure();
        snap_t      o, e;
        logic       acc;
        logic       sent1;
        logic [7:0] got[$];
        int         k;
        logic [2:0] codes [3] = '{3'd3, 3'd6, 3'd1};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, codes[(i < 2) ? i : 2], 1'b1, 1'b0, e, o, acc);
            checks++;
            if (o !== e) begin errors++; $display("FAIL bp_stall cyc %0d got %h exp %h", i, o, e); end
        end
        checks++;
        if ({o.ready_a, o.valid_a} !== 2'b01) begin
            errors++; $display("FAIL bp_full ready/valid got %b exp 01", {o.ready_a, o.valid_a});
        end
        sent1 = 1'b0;
        k     = 0;
        while ((!sent1 || o.valid_a || k == 0) && k < 20) begin
            do_cycle(!sent1, 3'd1, 1'b1, 1'b1, e, o, acc);
            if (acc) sent1 = 1'b1;
            if (o.valid_a) got.push_back(o.word_a);
            checks++;
            if (o !== e) begin errors++; $display("FAIL bp_drain cyc %0d got %h exp %h", k, o, e); end
            k++;
        end
        checks++;
        if (got.size() != 3 || got[0] !== 8'h08 || got[1] !== 8'h40 || got[2] !== 8'h02) begin
            errors++; $display("FAIL bp_order got %0d words %p exp 08 40 02", got.size(), got);
        end
    endtask

    task automatic test_wrap();
        snap_t      o, e;
        logic       acc;
        logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            do_cycle(k < 5, 3'(k), 1'b1, 1'b1, e, o, acc);
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap cyc %0d got %h exp %h", k, o, e); end
            if (k >= 2) begin
                checks++;
                if (o.cnt_b !== wrap_exp[k-2]) begin
                    errors++; $display("FAIL wrap_count %0d got %0d exp %0d", k - 2, o.cnt_b, wrap_exp[k-2]);
                end
            end
        end
    endtask

    task automatic test_random();
        snap_t      o, e;
        logic       acc, pend;
        logic [2:0] pc;
        logic       pe;
        int         sent, cyc;
        apply_reset();
        sent = 0; cyc = 0; pend = 1'b0; pc = 3'd0; pe = 1'b0;
        while ((sent < 1000 || mq.size() > 0) && cyc < 20000) begin
            if (!pend && sent < 1000 && ($urandom % 4) != 0) begin
                pend = 1'b1;
                pc   = 3'($urandom % 8);
                pe   = (($urandom % 8) != 0);
            end
            do_cycle(pend, pc, pe, 1'($urandom % 2), e, o, acc);
            if (acc) begin pend = 1'b0; sent++; end
            checks++;
            if (o !== e) begin errors++; $display("FAIL random cyc %0d got %h exp %h", cyc, o, e); end
            cyc++;
        end
        checks++;
        if (sent != 1000 || mq.size() != 0) begin
            errors++; $display("FAIL random_timeout sent %0d left %0d exp 1000/0", sent, mq.size());
        end
        do_cycle(1'b0, 3'd0, 1'b0, 1'b0, e, o, acc);
        checks++;
        if (o.cnt_a !== 8'd232) begin errors++; $display("FAIL random_count got %0d exp 232", o.cnt_a); end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        logic  acc;
        apply_reset();
        do_cycle(1'b1, 3'd4, 1'b1, 1'b0, e, o, acc);
        do_cycle(1'b1, 3'd7, 1'b1, 1'b0, e, o, acc);
        o = observe();
        checks++;
        if ({o.ready_a, o.valid_a} !== 2'b01) begin
            errors++; $display("FAIL mid_full ready/valid got %b exp 01", {o.ready_a, o.valid_a});
        end
        #2 rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        e = '{valid_a: 1'b0, ready_a: 1'b0, valid_b: 1'b0, ready_b: 1'b0,
              word_a: 8'h00, word_b: 8'hFF, cnt_a: 8'h00, cnt_b: 2'd0};
        o = observe();
        checks++;
        if (o !== e) begin errors++; $display("FAIL mid_reset_state got %h exp %h", o, e); end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            do_cycle(k == 0, 3'd3, 1'b1, 1'b1, e, o, acc);
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid cyc %0d got %h exp %h", k, o, e); end
            if (k == 1) begin
                checks++;
                if ({o.valid_a, o.word_a} !== {1'b1, 8'h08}) begin
                    errors++; $display("FAIL mid_first_out got %b/%h exp 1/08", o.valid_a, o.word_a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_enable_low();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
